// File: rtl/fifo_control.sv
// Pointer, occupancy and status-flag controller for a 2^ADDR_WIDTH-deep FIFO memory.
// Memory strobes are combinational from registered state; everything else is registered.
module fifo_control #(
    parameter int unsigned DATA_WIDTH = 12,
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset_L,
    input  logic                  push,
    input  logic                  pop,
    input  logic [ADDR_WIDTH:0]   umbral_alto,
    input  logic [ADDR_WIDTH:0]   umbral_bajo,
    output logic                  write_enable,
    output logic                  read_enable,
    output logic [ADDR_WIDTH-1:0] wr_ptr,
    output logic [ADDR_WIDTH-1:0] rd_ptr,
    output logic [ADDR_WIDTH:0]   fifo_count,
    output logic                  fifo_empty,
    output logic                  fifo_full,
    output logic                  almost_empty,
    output logic                  almost_full,
    output logic                  data_valid,
    output logic                  error
);

    localparam int unsigned CNT_W = ADDR_WIDTH + 1;
    localparam logic [CNT_W-1:0] DEPTH = CNT_W'(2 ** ADDR_WIDTH);

    // DATA_WIDTH only describes the attached memory; reject nonsense values at elaboration.
    if (DATA_WIDTH < 1) begin : g_bad_data_width
        $error("fifo_control: DATA_WIDTH must be at least 1");
    end

    // Flags decode the registered count only, so push/pop never reach them combinationally.
    assign fifo_empty   = (fifo_count == '0);
    assign fifo_full    = (fifo_count == DEPTH);
    assign almost_empty = (fifo_count <= umbral_bajo);
    assign almost_full  = (fifo_count >= umbral_alto);

    assign write_enable = push & ~fifo_full & reset_L;
    assign read_enable  = pop & ~fifo_empty & reset_L;

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            data_valid <= 1'b0;
            error      <= 1'b0;
        end else begin
            if (write_enable) begin
                wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            end
            if (read_enable) begin
                rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
            end
            case ({write_enable, read_enable})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
            // Dropped requests latch the sticky error until the next reset.
            error      <= error | (push & fifo_full) | (pop & fifo_empty);
            data_valid <= read_enable;
        end
    end

endmodule

// File: tb/tb_fifo_control.sv
// Directed bench for fifo_control: a behavioural 256x12 memory plus an occupancy
// reference track every cycle, with hand-computed checks at the scenario boundaries.
module tb_fifo_control;

    localparam int unsigned DW = 12;
    localparam int unsigned AW = 8;
    localparam int unsigned UA = 250;
    localparam int unsigned UB = 4;

    logic          clk = 1'b0;
    logic          reset_L;
    logic          push;
    logic          pop;
    logic [AW:0]   umbral_alto;
    logic [AW:0]   umbral_bajo;
    logic          write_enable;
    logic          read_enable;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   fifo_count;
    logic          fifo_empty;
    logic          fifo_full;
    logic          almost_empty;
    logic          almost_full;
    logic          data_valid;
    logic          error;

    int passed = 0;
    int total  = 0;

    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] data_in;
    logic [DW-1:0] data_out;

    int            mcount;
    logic          merr;
    logic          mdv;
    logic [DW-1:0] exp_dout;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp_q[$];

    always #5 clk = ~clk;

    fifo_control #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk          (clk),
        .reset_L      (reset_L),
        .push         (push),
        .pop          (pop),
        .umbral_alto  (umbral_alto),
        .umbral_bajo  (umbral_bajo),
        .write_enable (write_enable),
        .read_enable  (read_enable),
        .wr_ptr       (wr_ptr),
        .rd_ptr       (rd_ptr),
        .fifo_count   (fifo_count),
        .fifo_empty   (fifo_empty),
        .fifo_full    (fifo_full),
        .almost_empty (almost_empty),
        .almost_full  (almost_full),
        .data_valid   (data_valid),
        .error        (error)
    );

    // Behavioural registered-read memory driven by the DUT strobes.
    always @(posedge clk) begin
        if (write_enable) mem[wr_ptr] <= data_in;
        if (read_enable)  data_out    <= mem[rd_ptr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    // One clock cycle: drive, check strobes, clock, update reference, check registered outputs.
    task automatic cyc(input logic r, input logic p, input logic q);
        logic ewe;
        logic ere;
        reset_L = r;
        push    = p;
        pop     = q;
        data_in = wdata;
        ewe = r && p && (mcount != 256);
        ere = r && q && (mcount != 0);
        #1;
        check("write_enable", 32'(write_enable), 32'(ewe));
        check("read_enable", 32'(read_enable), 32'(ere));
        if (ere) exp_dout = exp_q.pop_front();
        if (ewe) begin
            exp_q.push_back(wdata);
            wdata = wdata + DW'(1);
        end
        @(posedge clk);
        #1;
        if (!r) begin
            mcount = 0;
            merr   = 1'b0;
            mdv    = 1'b0;
            exp_q.delete();
        end else begin
            merr   = merr | (p && mcount == 256) | (q && mcount == 0);
            mcount = mcount + (ewe ? 1 : 0) - (ere ? 1 : 0);
            mdv    = ere;
        end
        check("fifo_count", 32'(fifo_count), 32'(mcount));
        check("data_valid", 32'(data_valid), 32'(mdv));
        check("error", 32'(error), 32'(merr));
        check("almost_full", 32'(almost_full), 32'(mcount >= int'(UA)));
        check("almost_empty", 32'(almost_empty), 32'(mcount <= int'(UB)));
        if (mdv) check("read_data", 32'(data_out), 32'(exp_dout));
    endtask

    task automatic do_reset();
        cyc(1'b0, 1'b0, 1'b0);
        wdata = '0;
    endtask

    initial begin
        umbral_alto = (AW+1)'(UA);
        umbral_bajo = (AW+1)'(UB);
        reset_L = 1'b0;
        push = 1'b0;
        pop = 1'b0;
        data_in = '0;
        mcount = 0;
        merr = 1'b0;
        mdv = 1'b0;
        exp_dout = '0;
        wdata = '0;

        // Reset with both requests asserted.
        cyc(1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 1'b1);
        check("rst_wr_ptr", 32'(wr_ptr), 32'd0);
        check("rst_rd_ptr", 32'(rd_ptr), 32'd0);
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_empty", 32'(fifo_empty), 32'd1);
        check("rst_full", 32'(fifo_full), 32'd0);
        check("rst_almost_empty", 32'(almost_empty), 32'd1);
        check("rst_almost_full", 32'(almost_full), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_data_valid", 32'(data_valid), 32'd0);
        wdata = '0;

        // Fill: almost_full rises after the 250th push.
        for (int i = 0; i < 249; i++) cyc(1'b1, 1'b1, 1'b0);
        check("af_before_250", 32'(almost_full), 32'd0);
        cyc(1'b1, 1'b1, 1'b0);
        check("af_after_250", 32'(almost_full), 32'd1);
        for (int i = 0; i < 6; i++) cyc(1'b1, 1'b1, 1'b0);
        check("fill_full", 32'(fifo_full), 32'd1);
        check("fill_count", 32'(fifo_count), 32'd256);
        check("fill_wr_ptr", 32'(wr_ptr), 32'd0);
        check("fill_error", 32'(error), 32'd0);

        // Push on full: dropped, sticky error.
        cyc(1'b1, 1'b1, 1'b0);
        check("ovf_count", 32'(fifo_count), 32'd256);
        check("ovf_wr_ptr", 32'(wr_ptr), 32'd0);
        check("ovf_error", 32'(error), 32'd1);

        // Drain 256 words, order 0x000..0x0FF checked inside cyc.
        for (int i = 0; i < 256; i++) cyc(1'b1, 1'b0, 1'b1);
        check("drain_empty", 32'(fifo_empty), 32'd1);
        check("drain_rd_ptr", 32'(rd_ptr), 32'd0);
        check("drain_last_word", 32'(data_out), 32'h0FF);
        check("drain_error_sticky", 32'(error), 32'd1);

        // Pop on empty after reset.
        do_reset();
        check("reset_clears_error", 32'(error), 32'd0);
        cyc(1'b1, 1'b0, 1'b1);
        check("udf_count", 32'(fifo_count), 32'd0);
        check("udf_rd_ptr", 32'(rd_ptr), 32'd0);
        check("udf_error", 32'(error), 32'd1);

        // Count 10 with sustained push+pop across pointer wrap.
        do_reset();
        for (int i = 0; i < 10; i++) cyc(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 300; i++) cyc(1'b1, 1'b1, 1'b1);
        check("steady_count", 32'(fifo_count), 32'd10);
        check("steady_wr_ptr", 32'(wr_ptr), 32'd54);
        check("steady_rd_ptr", 32'(rd_ptr), 32'd44);
        check("steady_error", 32'(error), 32'd0);
        check("steady_last_word", 32'(data_out), 32'd299);

        // Push+pop on empty: only the write lands.
        do_reset();
        cyc(1'b1, 1'b1, 1'b1);
        check("pp_empty_count", 32'(fifo_count), 32'd1);
        check("pp_empty_wr_ptr", 32'(wr_ptr), 32'd1);
        check("pp_empty_rd_ptr", 32'(rd_ptr), 32'd0);
        check("pp_empty_error", 32'(error), 32'd1);
        check("pp_empty_dv", 32'(data_valid), 32'd0);

        // Push+pop on full: only the read lands.
        do_reset();
        for (int i = 0; i < 256; i++) cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b1);
        check("pp_full_count", 32'(fifo_count), 32'd255);
        check("pp_full_rd_ptr", 32'(rd_ptr), 32'd1);
        check("pp_full_wr_ptr", 32'(wr_ptr), 32'd0);
        check("pp_full_error", 32'(error), 32'd1);
        check("pp_full_word", 32'(data_out), 32'd0);

        // Reset mid-operation with push held, then reuse from address 0.
        do_reset();
        for (int i = 0; i < 100; i++) cyc(1'b1, 1'b1, 1'b0);
        check("mid_count_100", 32'(fifo_count), 32'd100);
        cyc(1'b0, 1'b1, 1'b0);
        check("mid_rst_count", 32'(fifo_count), 32'd0);
        check("mid_rst_wr_ptr", 32'(wr_ptr), 32'd0);
        check("mid_rst_rd_ptr", 32'(rd_ptr), 32'd0);
        wdata = 12'hABC;
        cyc(1'b1, 1'b1, 1'b0);
        check("mid_push_wr_ptr", 32'(wr_ptr), 32'd1);
        check("mid_push_mem0", 32'(mem[0]), 32'hABC);
        cyc(1'b1, 1'b0, 1'b1);
        check("mid_pop_word", 32'(data_out), 32'hABC);
        check("mid_pop_empty", 32'(fifo_empty), 32'd1);
        cyc(1'b1, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/fifo_control.md
# fifo_control

Pointer and flag controller for the 256×12 FIFO data memory. It sits directly upstream of the memory: it turns `push`/`pop` requests into `write_enable`, `read_enable`, `wr_ptr` and `rd_ptr` for the memory. It also keeps the occupancy count, the full/empty and threshold flags, a read-data-valid strobe aligned to the memory's registered read, and a sticky overflow/underflow error.

## Interface
- `DATA_WIDTH`, 12, width of the memory data word; only used for documentation and bench consistency, no datapath inside this block.
- `ADDR_WIDTH`, 8, pointer width; depth = 2^ADDR_WIDTH = 256.

- `clk`  in  1  single clock, all state updates on the rising edge.
- `reset_L`  in  1  synchronous, active-low reset.
- `push`  in  1  write request for the current cycle.
- `pop`  in  1  read request for the current cycle.
- `umbral_alto`  in  ADDR_WIDTH+1  almost-full threshold; must be stable while `reset_L`=1.
- `umbral_bajo`  in  ADDR_WIDTH+1  almost-empty threshold; must be stable while `reset_L`=1.
- `write_enable`  out  1  write strobe to the memory.
- `read_enable`  out  1  read strobe to the memory.
- `wr_ptr`  out  ADDR_WIDTH  memory write address.
- `rd_ptr`  out  ADDR_WIDTH  memory read address.
- `fifo_count`  out  ADDR_WIDTH+1  current occupancy, range 0..256.
- `fifo_empty`, `fifo_full`, `almost_empty`, `almost_full`  out  1 each  status flags.
- `data_valid`  out  1  `FIFO_data_out` of the memory is valid this cycle.
- `error`  out  1  sticky overflow/underflow indicator.

## Operation
- Strobe generation:
  - `write_enable` = `push` & ~`fifo_full` & `reset_L`.
  - `read_enable` = `pop` & ~`fifo_empty` & `reset_L`.
  - Both are combinational from registered state and inputs.
- Memory behaviour: it writes `FIFO_data_in` at `mem[wr_ptr]` and captures `mem[rd_ptr]` into `FIFO_data_out` on the same edge that samples the enables.
- Pointers:
  - On an accepted write, `wr_ptr` <= `wr_ptr`+1.
  - On an accepted read, `rd_ptr` <= `rd_ptr`+1.
  - Both are modulo 2^ADDR_WIDTH; 255 wraps to 0 with no special handling.
- Count update:
  - Write only: +1.
  - Read only: −1.
  - Both or neither: unchanged.
  - `fifo_count` never leaves 0..256.
- Flags are derived from registered `fifo_count`, so they change only after an edge:
  - `fifo_empty` = (count==0).
  - `fifo_full` = (count==256).
  - `almost_empty` = (count<=`umbral_bajo`).
  - `almost_full` = (count>=`umbral_alto`).
- Simultaneous push and pop:
  - Count between 1 and 255: both accepted, count unchanged, both pointers advance.
  - Empty: only the write is accepted; the pop is an underflow.
  - Full: only the read is accepted; the push is an overflow.
- Errors: a push while `fifo_full`, or a pop while `fifo_empty`, sets `error`. The request is dropped, and pointers and count are unaffected by the dropped side. `error` stays 1 until reset.
- `data_valid` <= `read_enable`, a one-cycle register that marks the cycle in which the memory output holds the popped word.
- Reset (`reset_L`=0 at an edge), including mid-operation:
  - `wr_ptr`=0, `rd_ptr`=0, `fifo_count`=0, `error`=0, `data_valid`=0.
  - Hence `fifo_empty`=1, `fifo_full`=0, `almost_empty`=1, and `almost_full`=(`umbral_alto`==0).
  - While `reset_L`=0, both enables are forced to 0.
  - Memory contents are not cleared; data present before reset is unreachable afterwards.

## Timing
- Write latency: push in cycle N means the word is in memory at edge N. `fifo_count`/flags update after edge N. A pop is possible from cycle N+1.
- Read latency: pop in cycle N gives `read_enable`=1 in N. The memory output and `data_valid`=1 are valid in cycle N+1.
- Throughput: one push and one pop per cycle sustained. No bubbles at pointer wrap.
- Flag timing: flags reflect occupancy after the previous edge, so there is no combinational path from `push`/`pop` to flags.
- Combinational paths: `push`/`pop` → enables only.
- Reset priority: `reset_L`=0 overrides `push`/`pop` in the same cycle.

## Test plan
- Reset then idle: hold `reset_L`=0 for 2 cycles with `push`=`pop`=1 → enables 0, pointers 0, `fifo_count`=0, `fifo_empty`=1, `error`=0, `data_valid`=0.
- Fill and drain, thresholds 250/4:
  - 256 consecutive pushes → `write_enable` high for 256 cycles, `fifo_full`=1, `wr_ptr`=0, `almost_full` rises after the 250th push.
  - 256 pops → data order preserved (0x000..0x0FF), `data_valid` one cycle after each `read_enable`, then `fifo_empty`=1.
- Overflow/underflow:
  - Push on full → `write_enable`=0, count stays 256, `error`=1.
  - After reset, pop on empty → `read_enable`=0, `error`=1.
- Simultaneous ops:
  - Count=10 with push+pop for 300 cycles → count stays 10, both pointers wrap past 255, read data matches write order.
  - Empty with push+pop → count becomes 1, `error`=1.
  - Full with push+pop → count becomes 255, `error`=1.
- Reset mid-operation: count=100, assert `reset_L`=0 for one cycle with `push`=1 → count 0, pointers 0, enables 0 during reset. The next push writes address 0.
